// File: rtl/stopwatch_input_ctrl_pkg.sv
// Shared definitions for the stopwatch input conditioning block.
// Contents:
//   state_t       - control FSM encoding (IDLE=0, RUN=1, PAUSE=2; 3 unused)
//   DEF_TICK_DIV  - default clk cycles per debounce sample tick
//   DEF_TICK_W    - default width of the tick counter
//   DEF_DB_LEN    - default number of equal samples to change a debounced level
package stopwatch_input_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV = 131072;
  localparam int DEF_TICK_W   = 17;
  localparam int DEF_DB_LEN   = 4;

endpackage

// File: rtl/stopwatch_input_ctrl_debounce.sv
// Conditions one raw push-button: 2-flop synchronizer, tick-sampled shift
// register with hysteresis, and a rising-edge one-pulse.
// Ports:
//   clk   - system clock
//   rst   - synchronous reset, active-high
//   tick  - sample strobe, one clk wide
//   raw   - asynchronous, bouncing button input
//   db    - debounced level (registered)
//   pulse - one clk pulse on each rising edge of db
module button_debounce #(
  parameter int DB_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic pulse
);

  logic [1:0]        sync;
  logic [DB_LEN-1:0] sh;
  logic [DB_LEN-1:0] sh_next;
  logic              db_q;

  // The pattern test looks at the register as it will be after this tick's
  // shift, so db changes on the same edge that completes the run of samples.
  assign sh_next = {sh[DB_LEN-2:0], sync[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      sh   <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      db_q <= db;
      if (tick) begin
        sh <= sh_next;
        if (&sh_next)
          db <= 1'b1;
        else if (~|sh_next)
          db <= 1'b0;
        // mixed samples: hold db (hysteresis)
      end
    end
  end

  // db and db_q both clear on rst, so no pulse can appear right after reset.
  assign pulse = db & ~db_q;

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch input conditioning: debounces the start and reset buttons and
// turns them into a run/pause level and a clean counter-clear pulse.
// Ports:
//   clk         - system clock
//   rst         - synchronous reset, active-high
//   btn_start   - raw start button (async, may bounce)
//   btn_reset   - raw reset button (async, may bounce)
//   start_db    - debounced start level
//   reset_db    - debounced reset level
//   start_pulse - one clk pulse on start_db rising edge
//   clr_pulse   - one clk pulse on reset_db rising edge (counter clear)
//   run         - 1 while counting (counter enable)
//   state       - FSM state for debug (IDLE=0, RUN=1, PAUSE=2)
// Handshake: none; all outputs are plain levels/pulses in the clk domain,
// valid every cycle, with no backpressure.
module stopwatch_input_ctrl
  import stopwatch_input_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int TICK_W   = DEF_TICK_W,
  parameter int DB_LEN   = DEF_DB_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_reset,
  output logic       start_db,
  output logic       reset_db,
  output logic       start_pulse,
  output logic       clr_pulse,
  output logic       run,
  output logic [1:0] state
);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  state_t            st;

  // Free-running sample divider shared by both debouncers.
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  button_debounce #(.DB_LEN(DB_LEN)) u_start_db (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .raw   (btn_start),
    .db    (start_db),
    .pulse (start_pulse)
  );

  button_debounce #(.DB_LEN(DB_LEN)) u_reset_db (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .raw   (btn_reset),
    .db    (reset_db),
    .pulse (clr_pulse)
  );

  // A held (or just-pressed) reset button pins the FSM in IDLE, which also
  // gives clear priority over a coincident start press. run is loaded with
  // the same decision as the next state so it never lags the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= ST_IDLE;
      run <= 1'b0;
    end else if (clr_pulse || reset_db) begin
      st  <= ST_IDLE;
      run <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start_pulse) begin
            st  <= ST_RUN;
            run <= 1'b1;
          end
        end
        ST_RUN: begin
          if (start_pulse) begin
            st  <= ST_PAUSE;
            run <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (start_pulse) begin
            st  <= ST_RUN;
            run <= 1'b1;
          end
        end
        default: begin
          st  <= ST_IDLE;
          run <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: doc/stopwatch_input_ctrl.md
Name: stopwatch_input_ctrl

Overview:
Conditions the two raw push-buttons (start, reset) before they reach the stopwatch counter. Each button goes through a 2-flop synchronizer, a sampled debouncer and a one-pulse edge detector. A small control FSM then turns the start presses into a run/pause level, and turns reset presses into a clean reset pulse. It sits directly upstream of the time counter, replacing the ad-hoc start/reset relays. All outputs are in the clk domain.

Parameters:
TICK_DIV, 131072, clk cycles per debounce sample tick (≥2)
TICK_W, 17, width of tick counter (≥ clog2(TICK_DIV))
DB_LEN, 4, consecutive equal samples needed to change debounced level (≥2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
btn_start  input  1  raw start button, asynchronous, may bounce
btn_reset  input  1  raw reset button, asynchronous, may bounce
start_db  output  1  debounced start level
reset_db  output  1  debounced reset level
start_pulse  output  1  one-clk pulse on start_db rising edge
clr_pulse  output  1  one-clk pulse on reset_db rising edge; drives counter reset
run  output  1  1 = counting, 0 = paused/idle; drives counter enable
state  output  2  FSM state for debug (IDLE=0, RUN=1, PAUSE=2)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Everything samples on posedge clk only.
- Reset values: start_db=0, reset_db=0, start_pulse=0, clr_pulse=0, run=0, state=IDLE. Sync flops, shift registers and tick counter are all 0.
- Synchronizer: 2 flops per button. The synced value lags the raw input by 2 cycles.
- Tick: a free-running counter counts 0..TICK_DIV-1 and then wraps to 0. tick=1 in the cycle where count==TICK_DIV-1, so the first tick after reset comes in cycle TICK_DIV-1. The tick is shared by both debouncers.
- Debounce, on each tick:
  - the synced bit shifts into a DB_LEN shift register;
  - all ones sets db to 1; all zeros sets db to 0; a mixed register holds db (hysteresis).
  - db updates in the same cycle as the shift that completes the pattern.
- One-pulse: pulse = db & ~db_q, where db_q is db delayed one clk. The pulse is exactly 1 cycle wide per rising edge. No pulse on a falling edge. Holding a button produces only one pulse.
- Worst-case press latency from a stable raw edge to the pulse: 2 + DB_LEN*TICK_DIV + 1 cycles. Glitches shorter than (DB_LEN-1)*TICK_DIV cycles never change db.
- FSM, on clk:
  - IDLE: start_pulse goes to RUN.
  - RUN: start_pulse goes to PAUSE.
  - PAUSE: start_pulse goes to RUN.
  - Any state: clr_pulse goes to IDLE. clr_pulse has priority over start_pulse in the same cycle.
  - run = (state==RUN), registered, so it follows state with no extra lag.
- Simultaneous presses: if both pulses are high in one cycle, the result is IDLE and run=0.
- Held reset_db: while reset_db is high, start_pulse is ignored and state stays IDLE.
- rst mid-operation: all state clears next edge, including partially filled shift registers. No pulse is emitted on the first cycle after rst drops, even if a button is held. A held button needs DB_LEN ticks before db rises, then yields one pulse.
- Unused encoding 3 returns to IDLE.

Decomposition:
- Shared package: FSM state constants (ST_IDLE, ST_RUN, ST_PAUSE) and default TICK_DIV/DB_LEN.
- Sub-module button_debounce (sync + shift register + hysteresis + one-pulse; inputs clk, rst, tick, raw; outputs db, pulse), instantiated twice.
- The tick counter and FSM live in the top module.

Test Plan:
Use TICK_DIV=4, DB_LEN=4 for all scenarios.
1. Reset values: hold rst 5 cycles → all outputs 0, state=0. Release rst with buttons low for 40 cycles → no pulses.
2. Clean press: btn_start rises at cycle 10 and is held for 40 cycles → start_db rises within 2+16+1 cycles. start_pulse is high exactly 1 cycle, run=1 the cycle after, state=1.
3. Bounce: btn_start toggles every 3 cycles for 30 cycles, then is held high → exactly one start_pulse, none during toggling.
4. Toggle sequence: three separate clean start presses → state 1, then 2, then 1. run is 1, then 0, then 1.
5. Clear: in RUN, press btn_reset → one clr_pulse, state=0, run=0. Then a start press while reset is still held → state stays 0.
6. Simultaneous and mid-op reset:
   - btn_start and btn_reset rise in the same cycle → pulses coincide, state=0.
   - Assert rst mid-debounce with btn_start held → all outputs clear. After release, one start_pulse follows after 16+ cycles.
